// File: rtl/icmp_gen_pkg.sv
// icmp_gen_pkg: mode and FSM encodings plus LFSR constants for the ICMP/UDP traffic generator.
package icmp_gen_pkg;
    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_WALK  = 2'd3
    } mode_e;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_GAP,
        ST_FINISH
    } state_e;
    // Galois form of x^32+x^22+x^2+x+1, shifting right
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? (s >> 1) ^ LFSR_POLY : s >> 1;
    endfunction
endpackage

// File: rtl/icmp_traffic_gen_if.sv
// icmp_traffic_gen_if: tx handshake between the packet generator and the ICMP/UDP tx path.
interface icmp_traffic_gen_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              tx_start_en;
    logic [LEN_W-1:0]  tx_byte_num;
    logic [DATA_W-1:0] tx_data;
    logic              tx_req;
    logic              tx_done;
    modport master (output tx_start_en, tx_byte_num, tx_data, input tx_req, tx_done);
    modport slave  (input tx_start_en, tx_byte_num, tx_data, output tx_req, tx_done);
endinterface

// File: rtl/icmp_gen_pattern.sv
// icmp_gen_pattern: payload pattern register with per-run mode latch, seeding and per-word advance.
module icmp_gen_pattern
    import icmp_gen_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              gmii_clk,
    input  logic              sys_rst,
    input  logic              load,
    input  logic              reseed,
    input  logic              adv,
    input  logic [1:0]        mode_in,
    input  logic [DATA_W-1:0] const_word,
    output logic [DATA_W-1:0] data
);
    mode_e             mode;
    mode_e             seed_mode;
    logic [DATA_W-1:0] word;
    logic [31:0]       lfsr;
    assign seed_mode = load ? mode_e'(mode_in) : mode;
    assign data = (mode == MODE_CONST) ? const_word :
                  (mode == MODE_LFSR)  ? lfsr[DATA_W-1:0] : word;
    // word serves both incrementing and walking-one patterns
    always_ff @(posedge gmii_clk or posedge sys_rst)
        if (sys_rst) begin
            mode <= MODE_INCR;
            word <= '0;
            lfsr <= LFSR_SEED;
        end else begin
            if (load)
                mode <= mode_e'(mode_in);
            if (load || reseed) begin
                word <= (seed_mode == MODE_INCR) ? '0 : DATA_W'(1);
                lfsr <= LFSR_SEED;
            end else if (adv) begin
                word <= (mode == MODE_INCR) ? word + DATA_W'(1) : {word[DATA_W-2:0], word[DATA_W-1]};
                lfsr <= lfsr_step(lfsr);
            end
        end
endmodule

// File: rtl/icmp_traffic_gen.sv
// icmp_traffic_gen: programmable packet stimulus engine driving the ICMP/UDP tx handshake.
module icmp_traffic_gen
    import icmp_gen_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 16,
    parameter int NUM_PKTS    = 2,
    parameter int LEN_START   = 20,
    parameter int LEN_STEP    = 8,
    parameter int LEN_MAX     = 1472,
    parameter int GAP_CYCLES  = 100,
    parameter int TIMEOUT_CYC = 16383
) (
    input  logic                gmii_clk,
    input  logic                sys_rst,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   const_word,
    icmp_traffic_gen_if.master  tx,
    output logic                busy,
    output logic                done,
    output logic [15:0]         pkt_cnt,
    output logic                timeout_err
);
    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYCLES) ? TIMEOUT_CYC : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [LEN_W-1:0] len;
    logic [LEN_W:0]   len_sum;
    logic             run_go, pkt_ok, pkt_to, gap_end, fin;
    assign run_go  = (state == ST_IDLE) && enable;
    assign pkt_ok  = (state == ST_WAIT) && tx.tx_done;
    assign pkt_to  = (state == ST_WAIT) && !tx.tx_done && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign gap_end = (state == ST_GAP) && (cnt == CNT_W'(GAP_CYCLES - 1));
    assign fin     = ((NUM_PKTS != 0) && (pkt_cnt == 16'(NUM_PKTS))) || !enable;
    // one extra bit so an overflowing ramp reloads instead of wrapping
    assign len_sum = {1'b0, len} + (LEN_W+1)'(LEN_STEP);
    assign tx.tx_byte_num = (state == ST_START || state == ST_WAIT) ? len : '0;
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:   state_nxt = enable ? ST_START : ST_IDLE;
            ST_START: begin
                busy      = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy      = 1'b1;
                state_nxt = (pkt_ok || pkt_to) ? ST_GAP : ST_WAIT;
            end
            ST_GAP: begin
                busy      = 1'b1;
                state_nxt = !gap_end ? ST_GAP : fin ? ST_FINISH : ST_START;
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = enable ? ST_FINISH : ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end
    // start pulse is registered so reset or decode never glitches it
    always_ff @(posedge gmii_clk or posedge sys_rst)
        if (sys_rst) begin
            state          <= ST_IDLE;
            tx.tx_start_en <= 1'b0;
        end else begin
            state          <= state_nxt;
            tx.tx_start_en <= (state_nxt == ST_START);
        end
    always_ff @(posedge gmii_clk or posedge sys_rst)
        if (sys_rst) begin
            cnt         <= '0;
            len         <= LEN_W'(LEN_START);
            pkt_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt <= (state_nxt != state || !busy) ? '0 : cnt + CNT_W'(1);
            if (run_go)
                len <= LEN_W'(LEN_START);
            else if (gap_end && state_nxt == ST_START)
                len <= (len_sum > (LEN_W+1)'(LEN_MAX)) ? LEN_W'(LEN_START) : len_sum[LEN_W-1:0];
            if (run_go)
                pkt_cnt <= '0;
            else if (pkt_ok)
                pkt_cnt <= pkt_cnt + 16'd1;
            if (run_go)
                timeout_err <= 1'b0;
            else if (pkt_to)
                timeout_err <= 1'b1;
        end
    icmp_gen_pattern #(.DATA_W(DATA_W)) u_pattern (
        .gmii_clk   (gmii_clk),
        .sys_rst    (sys_rst),
        .load       (run_go),
        .reseed     (pkt_ok || pkt_to),
        .adv        ((state == ST_WAIT) && tx.tx_req),
        .mode_in    (mode),
        .const_word (const_word),
        .data       (tx.tx_data)
    );
endmodule

// File: tb/tb_icmp_traffic_gen.sv
// tb_icmp_traffic_gen: randomized scoreboard bench for icmp_traffic_gen with a pattern/length reference model.
module tb_icmp_traffic_gen;
    localparam int GAP  = 5;
    localparam int TMO  = 64;
    localparam int NPK  = 3;
    localparam int LS   = 1400;
    localparam int STEP = 50;
    localparam int LMAX = 1472;

    logic        gmii_clk, sys_rst, enable, chk_req;
    logic [1:0]  mode;
    logic [31:0] const_word;
    logic        busy, done, timeout_err;
    logic [15:0] pkt_cnt;
    int          n_cmp = 0, n_bad = 0;
    longint      cyc = 0;

    icmp_traffic_gen_if #(.DATA_W(32), .LEN_W(16)) tx_if ();

    icmp_traffic_gen #(
        .DATA_W(32), .LEN_W(16), .NUM_PKTS(NPK), .LEN_START(LS), .LEN_STEP(STEP),
        .LEN_MAX(LMAX), .GAP_CYCLES(GAP), .TIMEOUT_CYC(TMO)
    ) dut (
        .gmii_clk    (gmii_clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .mode        (mode),
        .const_word  (const_word),
        .tx          (tx_if),
        .busy        (busy),
        .done        (done),
        .pkt_cnt     (pkt_cnt),
        .timeout_err (timeout_err)
    );

    initial begin
        gmii_clk = 1'b0;
        forever #5 gmii_clk = ~gmii_clk;
    end
    always @(posedge gmii_clk) cyc <= cyc + 1;

    logic [31:0] q_data[$];
    logic [15:0] q_len[$];
    logic [16:0] q_end[$];
    logic [31:0] lfsr_seq[64];
    int          m_mode, m_len, m_k, m_cnt;
    logic        m_terr;
    logic [31:0] m_const;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // k-th word after a seed, straight from the pattern definitions
    function automatic logic [31:0] model_word(input int k);
        case (m_mode)
            0:       return 32'(k);
            1:       return m_const;
            2:       return lfsr_seq[k];
            default: return 32'h1 << (k % 32);
        endcase
    endfunction

    // monitor: compares whatever the DUT presents against queued expectations
    initial begin
        longint done_cyc = 0, start_cyc = 0;
        bit     have_done = 0, prev_terr = 0, prev_done = 0;
        logic [16:0] e;
        forever begin
            @(negedge gmii_clk);
            if (sys_rst) begin
                have_done = 0;
                prev_terr = 0;
                prev_done = 0;
            end else begin
                if (tx_if.tx_start_en) begin
                    if (q_len.size() == 0) check("unexpected_start", 1, 0);
                    else check("byte_num", tx_if.tx_byte_num, q_len.pop_front());
                    if (have_done) check("done_to_start", cyc - done_cyc, GAP + 1);
                    have_done = 0;
                    start_cyc = cyc;
                end
                if (tx_if.tx_req && chk_req) begin
                    if (q_data.size() == 0) check("unexpected_req", 1, 0);
                    else check("tx_data", tx_if.tx_data, q_data.pop_front());
                end
                if (tx_if.tx_done) begin
                    have_done = 1;
                    done_cyc  = cyc;
                end
                if (timeout_err && !prev_terr) check("timeout_latency", cyc - start_cyc, TMO + 1);
                if (done && !prev_done) begin
                    if (q_end.size() == 0) check("unexpected_done", 1, 0);
                    else begin
                        e = q_end.pop_front();
                        check("run_pkt_cnt", pkt_cnt, e[16:1]);
                        check("run_timeout_err", timeout_err, e[0]);
                    end
                    check("busy_in_finish", busy, 0);
                    have_done = 0;
                end
                prev_terr = timeout_err;
                prev_done = done;
            end
        end
    end

    task automatic step();
        @(posedge gmii_clk);
        #1;
        tx_if.tx_req  = 1'b0;
        tx_if.tx_done = 1'b0;
        chk_req       = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        @(negedge gmii_clk);
        while (!tx_if.tx_start_en && n < GAP + 20) begin
            @(negedge gmii_clk);
            n++;
        end
        if (!tx_if.tx_start_en) check("start_seen", 0, 1);
    endtask

    task automatic run_begin(input int md);
        step();
        m_mode     = md;
        m_const    = $urandom();
        const_word = m_const;
        m_len      = LS;
        m_k        = 0;
        m_cnt      = 0;
        m_terr     = 0;
        mode       = 2'(md);
        enable     = 1'b1;
    endtask

    // fin: 0 = tx_done, 1 = tx_done with tx_req, 2 = never finish (watchdog)
    task automatic pkt(input int nreq, input int fin, input int idle_max, input int drop_at);
        int n = 0;
        q_len.push_back(16'(m_len));
        m_len = (m_len + STEP > LMAX) ? LS : m_len + STEP;
        wait_start();
        for (int i = 0; i < nreq; i++) begin
            repeat ($urandom_range(0, idle_max)) step();
            step();
            tx_if.tx_req = 1'b1;
            chk_req      = 1'b1;
            q_data.push_back(model_word(m_k));
            m_k++;
            if (i == drop_at) enable = 1'b0;
        end
        if (fin == 2) begin
            step();
            while (!timeout_err && n < TMO + 8) begin
                step();
                n++;
            end
            if (!timeout_err) check("timeout_seen", 0, 1);
            m_terr = 1;
        end else begin
            step();
            tx_if.tx_done = 1'b1;
            if (fin == 1) begin
                tx_if.tx_req = 1'b1;
                chk_req      = 1'b1;
                q_data.push_back(model_word(m_k));
            end
            m_cnt++;
            step();
            tx_if.tx_req = 1'b1;  // stray request during GAP must be ignored
            step();
        end
        m_k = 0;
    endtask

    task automatic run_end();
        int n = 0;
        q_end.push_back({16'(m_cnt), m_terr});
        while (!done && n < GAP + 10) begin
            step();
            n++;
        end
        check("done_seen", done, 1);
        enable = 1'b0;
        step();
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        logic [31:0] s = 32'h1;
        for (int i = 0; i < 64; i++) begin
            lfsr_seq[i] = s;
            s = s[0] ? (s >> 1) ^ 32'h8020_0003 : s >> 1;
        end
        sys_rst = 1'b1; enable = 1'b0; mode = 2'd0; const_word = '0; chk_req = 1'b0;
        tx_if.tx_req = 1'b0; tx_if.tx_done = 1'b0;
        repeat (3) @(negedge gmii_clk);
        check("rst_outputs", {tx_if.tx_start_en, tx_if.tx_byte_num, tx_if.tx_data, busy, done, pkt_cnt, timeout_err}, 0);
        step();
        sys_rst = 1'b0;
        @(negedge gmii_clk);
        check("post_rst_outputs", {tx_if.tx_start_en, tx_if.tx_byte_num, tx_if.tx_data, busy, done, pkt_cnt, timeout_err}, 0);
        // incrementing payload, length ramp with reload, simultaneous req+done
        run_begin(0);
        pkt($urandom_range(3, 10), 0, 2, -1);
        pkt($urandom_range(3, 10), 1, 2, -1);
        pkt($urandom_range(3, 10), 0, 2, -1);
        run_end();
        // LFSR with a watchdog-abandoned packet and an ignored mid-run mode change
        run_begin(2);
        pkt($urandom_range(3, 10), 0, 1, -1);
        mode = 2'd3;
        pkt($urandom_range(2, 6), 2, 1, -1);
        pkt($urandom_range(3, 10), 1, 1, -1);
        pkt($urandom_range(3, 10), 0, 1, -1);
        run_end();
        // walking one through a full rotation; enable drops mid-packet
        run_begin(3);
        pkt(33, 0, 0, 5);
        run_end();
        // constant payload, then reset while waiting for tx_done
        run_begin(1);
        pkt($urandom_range(3, 8), 0, 1, -1);
        q_len.push_back(16'(m_len));
        wait_start();
        step();
        tx_if.tx_req = 1'b1;
        chk_req      = 1'b1;
        q_data.push_back(model_word(m_k));
        step();
        check("pkt_cnt_before_rst", pkt_cnt, 16'(m_cnt));
        sys_rst = 1'b1;
        enable  = 1'b0;
        @(negedge gmii_clk);
        check("midrun_rst_outputs", {tx_if.tx_start_en, tx_if.tx_byte_num, tx_if.tx_data, busy, done, pkt_cnt, timeout_err}, 0);
        step();
        sys_rst = 1'b0;
        repeat (3) step();
        check("q_len_empty", q_len.size(), 0);
        check("q_data_empty", q_data.size(), 0);
        check("q_end_empty", q_end.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete by cycle %0d", cyc);
        $fatal(1, "global timeout");
    end
endmodule
